// File: rtl/defines_pkg.sv
// Shared MVM sizing defaults, driver state encoding and a sizing helper.
package defines_pkg;

    localparam int MVM_NROWS_A = 3;
    localparam int MVM_NCOLS_A = 3;
    localparam int MVM_NROWS_B = 3;
    localparam int MVM_NCOLS_B = 1;

    typedef enum logic [1:0] {DRV_IDLE, DRV_RUN, DRV_DONE} drv_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory.sv
// Simple dual-port RAM: synchronous write, synchronous read (one-cycle latency).
// A same-address read during a write returns the newly written word.
module memory #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 16,
    localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mvm_skid2.sv
// Two-entry valid/ready skid buffer with registered outputs; exposes its fill level
// so the producer can issue reads ahead of a one-cycle memory latency.
module mvm_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign level     = count_q;

    always_comb begin
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop keeps the level; the new word lands behind any survivor.
                if (count_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mvm_stream_driver.sv
// Host-side MVM stream driver: streams A then B from operand memory, captures results.
// Optional overflow counter enabled by defining MVM_DRV_OVF_CNT_EN.
module mvm_stream_driver
    import defines_pkg::*;
#(
    parameter int NROWS_A = MVM_NROWS_A,
    parameter int NCOLS_A = MVM_NCOLS_A,
    parameter int NROWS_B = MVM_NROWS_B,
    parameter int NCOLS_B = MVM_NCOLS_B,
    localparam int SA     = NROWS_A * NCOLS_A,
    localparam int SB     = NROWS_B * NCOLS_B,
    localparam int OPW    = $clog2(SA + SB),
    localparam int RW     = clog2_min1(NROWS_A)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           ld_wr_en,
    input  logic [OPW-1:0] ld_addr,
    input  logic [7:0]     ld_data,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    input  logic [15:0]    rx_data,
    input  logic           rx_overflow,
    input  logic           rx_valid,
    output logic           rx_ready,
    input  logic [RW-1:0]  res_addr,
    output logic [15:0]    res_data,
    output logic           res_overflow,
    output logic           busy,
    output logic           done,
    output logic [RW:0]    ovf_count
);

    localparam int TOTAL = SA + SB;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [RW:0]   NRES_C  = (RW + 1)'(NROWS_A);

    drv_state_t state_q, state_d;

    logic [CW-1:0]  issued_q, issued_d;
    logic [CW-1:0]  sent_q, sent_d;
    logic [RW:0]    recv_q, recv_d;
    logic           inflight_q, inflight_d;

    logic           entering;
    logic           issue_run;
    logic           tx_hs;
    logic           rx_hs;
    logic [2:0]     occ;
    logic [1:0]     skid_level;
    logic           skid_in_ready;
    logic [7:0]     op_rd_data;
    logic [OPW-1:0] op_rd_addr;
    logic [16:0]    res_rd_data;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= DRV_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DRV_IDLE, DRV_DONE: if (start) state_d = DRV_RUN;
            DRV_RUN:            if ((sent_d == TOTAL_C) && (recv_d == NRES_C)) state_d = DRV_DONE;
            default:            state_d = DRV_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state_q == DRV_RUN);
        done     = (state_q == DRV_DONE);
        rx_ready = (state_q == DRV_RUN) && (recv_q < NRES_C);
    end

    // Reads are issued only when the word can still fit in the skid buffer once it
    // returns a cycle later; the start cycle itself issues address 0.
    always_comb begin
        entering   = (state_q != DRV_RUN) && start;
        tx_hs      = tx_valid && tx_ready;
        rx_hs      = rx_valid && rx_ready;
        occ        = {1'b0, skid_level} + {2'b00, inflight_q} - {2'b00, tx_hs};
        issue_run  = (state_q == DRV_RUN) && (issued_q < TOTAL_C) && (occ <= 3'd1);
        op_rd_addr = entering ? '0 : issued_q[OPW-1:0];
        inflight_d = entering || issue_run;
        if (entering) begin
            issued_d = CW'(1);
            sent_d   = '0;
            recv_d   = '0;
        end else begin
            issued_d = issued_q + CW'(issue_run);
            sent_d   = sent_q + CW'(tx_hs);
            recv_d   = recv_q + (RW + 1)'(rx_hs);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q   <= '0;
            sent_q     <= '0;
            recv_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            recv_q     <= recv_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef MVM_DRV_OVF_CNT_EN
    logic [RW:0] ovf_q, ovf_d;

    always_comb begin
        if (entering) ovf_d = '0;
        else          ovf_d = ovf_q + (RW + 1)'(rx_hs && rx_overflow);
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = '0;
`endif

    memory #(
        .WIDTH (8),
        .SIZE  (SA + SB)
    ) u_op_mem (
        .clk     (clk),
        .wr_en   (ld_wr_en && (state_q != DRV_RUN)),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (op_rd_addr),
        .rd_data (op_rd_data)
    );

    mvm_skid2 #(
        .WIDTH (8)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_ready  (skid_in_ready),
        .in_data   (op_rd_data),
        .out_valid (tx_valid),
        .out_ready (tx_ready),
        .out_data  (tx_data),
        .level     (skid_level)
    );

    memory #(
        .WIDTH (17),
        .SIZE  (NROWS_A)
    ) u_res_mem (
        .clk     (clk),
        .wr_en   (rx_hs),
        .wr_addr (recv_q[RW-1:0]),
        .wr_data ({rx_overflow, rx_data}),
        .rd_addr (res_addr),
        .rd_data (res_rd_data)
    );

    assign res_data     = res_rd_data[15:0];
    assign res_overflow = res_rd_data[16];

    // Credit accounting guarantees the skid never sees a push while full.
    logic unused_ok;
    assign unused_ok = skid_in_ready;

endmodule
